myproject_mac_pipe: RTL

MYPROJECT_MAC_PIPE -- requirements
Module: myproject_mac_pipe

---
 rtl/myproject_mac_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe
//   Pipelined multiplier with an optional saturating accumulator.
//   Each operand is widened by one bit (sign or zero extension, chosen per
//   operand) and the two are multiplied as signed numbers. The product then
//   moves through NUM_STAGE-1 intermediate registers. Stage NUM_STAGE is the
//   output register dout.
//   With ACC_MODE=0, dout takes the product, truncated or sign-extended to
//   the dout width.
//   With ACC_MODE=1, dout is the accumulator. It saturates to the signed
//   dout range, and ovf is a sticky saturation flag.
//
// Parameters
//   ID           instance tag, no functional effect
//   NUM_STAGE    total register stages including dout, legal range 1..4
//   din0_WIDTH   operand 0 width
//   din1_WIDTH   operand 1 width
//   dout_WIDTH   result / accumulator width
//   DIN0_SIGNED  1 = din0 is two's complement, 0 = unsigned
//   DIN1_SIGNED  1 = din1 is two's complement, 0 = unsigned
//   ACC_MODE     0 = pipelined multiply, 1 = saturating multiply-accumulate
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-low reset; clears every register
//   ce       clock enable; nothing changes while low
//   vld_in   din0/din1/clr form a valid sample
//   clr      in ACC_MODE=1 this sample restarts the accumulation
//   din0     operand 0
//   din1     operand 1
//   dout     result
//   vld_out  dout was updated by a valid sample on this cycle
//   ovf      sticky saturation flag (always 0 when ACC_MODE=0)
module myproject_mac_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 16,
  parameter int din1_WIDTH  = 5,
  parameter int dout_WIDTH  = 21,
  parameter int DIN0_SIGNED = 1,
  parameter int DIN1_SIGNED = 0,
  parameter int ACC_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  vld_in,
  input  logic                  clr,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  vld_out,
  output logic                  ovf
);

  localparam int P  = din0_WIDTH + din1_WIDTH + 2;
  // The extra bit of headroom keeps acc + product from wrapping before the clamp.
  localparam int SW = ((P > dout_WIDTH) ? P : dout_WIDTH) + 1;

  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};

  logic [din0_WIDTH:0]   ext0;
  logic [din1_WIDTH:0]   ext1;
  logic signed [P-1:0]   op0;
  logic signed [P-1:0]   op1;
  logic signed [P-1:0]   prod;

  logic signed [P-1:0]   fin_prod;
  logic                  fin_vld;
  logic                  fin_clr;

  logic signed [SW-1:0]  prod_ext;
  logic signed [SW-1:0]  acc_ext;
  logic signed [SW-1:0]  base;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  acc_next;
  logic                  sat_hit;
  logic                  ovf_next;

  assign ext0 = {((DIN0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0), din0};
  assign ext1 = {((DIN1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0), din1};

  // Both operands are widened to the full product width. The low P bits of
  // the multiply then equal the exact signed product.
  assign op0  = {{(din1_WIDTH+1){ext0[din0_WIDTH]}}, ext0};
  assign op1  = {{(din0_WIDTH+1){ext1[din1_WIDTH]}}, ext1};
  assign prod = op0 * op1;

  generate
    if (NUM_STAGE == 1) begin : g_no_pipe
      assign fin_prod = prod;
      assign fin_vld  = vld_in;
      assign fin_clr  = clr;
    end else begin : g_pipe
      localparam int D = NUM_STAGE - 1;
      logic signed [P-1:0] prod_q [D];
      logic [D-1:0]        vld_q;
      logic [D-1:0]        clr_q;

      // The intermediate stages load on every enabled edge, whether or not
      // the sample is valid. Each sample's vld/clr tags travel with its product.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < D; i++) begin
            prod_q[i] <= '0;
          end
          vld_q <= '0;
          clr_q <= '0;
        end else if (ce) begin
          prod_q[0] <= prod;
          vld_q[0]  <= vld_in;
          clr_q[0]  <= clr;
          for (int i = 1; i < D; i++) begin
            prod_q[i] <= prod_q[i-1];
            vld_q[i]  <= vld_q[i-1];
            clr_q[i]  <= clr_q[i-1];
          end
        end
      end

      assign fin_prod = prod_q[D-1];
      assign fin_vld  = vld_q[D-1];
      assign fin_clr  = clr_q[D-1];
    end
  endgenerate

  // With ACC_MODE=0 the base is forced to zero and no clamp is applied.
  // The low dout bits of the widened product then give the wrapped product,
  // or the sign-extended product when dout is wider than the product.
  always_comb begin
    prod_ext = {{(SW-P){fin_prod[P-1]}}, fin_prod};
    acc_ext  = {{(SW-dout_WIDTH){dout[dout_WIDTH-1]}}, dout};
    base     = ((ACC_MODE != 0) && !fin_clr) ? acc_ext : '0;
    sum      = base + prod_ext;
    acc_next = sum;
    sat_hit  = 1'b0;
    ovf_next = 1'b0;
    if (ACC_MODE != 0) begin
      if (sum > SAT_MAX) begin
        acc_next = SAT_MAX;
        sat_hit  = 1'b1;
      end else if (sum < SAT_MIN) begin
        acc_next = SAT_MIN;
        sat_hit  = 1'b1;
      end
      ovf_next = fin_clr ? sat_hit : (ovf | sat_hit);
    end
  end

  // dout also serves as the accumulator. Only a valid final-stage sample
  // may change dout or ovf, so bubbles leave both untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout    <= '0;
      vld_out <= 1'b0;
      ovf     <= 1'b0;
    end else if (ce) begin
      vld_out <= fin_vld;
      if (fin_vld) begin
        dout <= acc_next[dout_WIDTH-1:0];
        ovf  <= ovf_next;
      end
    end
  end

endmodule
